// File: rtl/jtag_host_if.sv
// jtag_host_if: command/response handshake between a scan initiator
// and the jtag_host driver (master issues scans, slave runs them).
interface jtag_host_if #(
  parameter int REG_W = 8
);
  logic             i_valid;
  logic             o_ready;
  logic             i_isIr;
  logic             i_tapReset;
  logic [REG_W-1:0] i_data;
  logic             o_rspValid;
  logic [REG_W-1:0] o_rspData;

  modport master (
    output i_valid, i_isIr, i_tapReset, i_data,
    input  o_ready, o_rspValid, o_rspData
  );

  modport slave (
    input  i_valid, i_isIr, i_tapReset, i_data,
    output o_ready, o_rspValid, o_rspData
  );
endinterface

// File: rtl/jtag_host.sv
// jtag_host: host-side JTAG driver running IR/DR scans and TAP resets.
// Optional JTAG_HOST_TRST_EN: adds o_trst_n, low for 2 TCK periods of reset.
module jtag_host #(
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  jtag_host_if.slave cmd,
  output logic       o_tck,
  output logic       o_tms,
  output logic       o_tdi,
`ifdef JTAG_HOST_TRST_EN
  output logic       o_trst_n,
`endif
  input  logic       i_tdo
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = (REG_W > 1) ? $clog2(REG_W) : 1;
`ifdef JTAG_HOST_TRST_EN
  localparam int INIT_N = 8;
`else
  localparam int INIT_N = 6;
`endif
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    INIT, IDLE, PRE, SHIFT, POST, DONE
  } st_e;

  st_e              st_q, st_d, nst;
  logic [DW-1:0]    div_q, div_d;
  logic             hi_q, hi_d;
  logic [15:0]      per_q, per_d, nper, last;
  logic             ir_q, ir_d, ir_s;
  logic [REG_W-1:0] dat_q, dat_d, dat_s;
  logic [REG_W-1:0] sh_q, sh_d;
  logic [REG_W-1:0] rsp_q, rsp_d;
  logic             tck_q, tck_d;
  logic             tms_q, tms_d;
  logic             tdi_q, tdi_d;
  logic             go;
`ifdef JTAG_HOST_TRST_EN
  logic             trst_q, trst_d;
`endif

  // State and output registers; reset parks the divider at a period end
  // so INIT's first period starts on the first edge after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q   <= INIT;
      div_q  <= DMAX;
      hi_q   <= 1'b1;
      per_q  <= '1;
      ir_q   <= 1'b0;
      dat_q  <= '0;
      sh_q   <= '0;
      rsp_q  <= '0;
      tck_q  <= 1'b0;
      tms_q  <= 1'b1;
      tdi_q  <= 1'b0;
`ifdef JTAG_HOST_TRST_EN
      trst_q <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      div_q  <= div_d;
      hi_q   <= hi_d;
      per_q  <= per_d;
      ir_q   <= ir_d;
      dat_q  <= dat_d;
      sh_q   <= sh_d;
      rsp_q  <= rsp_d;
      tck_q  <= tck_d;
      tms_q  <= tms_d;
      tdi_q  <= tdi_d;
`ifdef JTAG_HOST_TRST_EN
      trst_q <= trst_d;
`endif
    end
  end

  // Next state: divider, period sequencing, TMS/TDI per period, TDO capture.
  always_comb begin
    st_d  = st_q;
    div_d = div_q;
    hi_d  = hi_q;
    per_d = per_q;
    ir_d  = ir_q;
    dat_d = dat_q;
    sh_d  = sh_q;
    rsp_d = rsp_q;
    tck_d = tck_q;
    tms_d = tms_q;
    tdi_d = tdi_q;
`ifdef JTAG_HOST_TRST_EN
    trst_d = trst_q;
`endif
    nst   = st_q;
    nper  = per_q;
    go    = 1'b0;
    ir_s  = ir_q;
    dat_s = dat_q;
    unique case (st_q)
      INIT:    last = 16'(INIT_N - 1);
      PRE:     last = ir_q ? 16'd3 : 16'd2;
      SHIFT:   last = 16'(REG_W - 1);
      default: last = 16'd1;
    endcase
    if (st_q == IDLE || st_q == DONE) begin
      st_d = IDLE;
      if (cmd.i_valid) begin
        go    = 1'b1;
        ir_s  = cmd.i_isIr;
        dat_s = cmd.i_data;
        ir_d  = cmd.i_isIr;
        dat_d = cmd.i_data;
        nst   = cmd.i_tapReset ? INIT : PRE;
        nper  = 16'd0;
      end
    end else if (div_q == DMAX) begin
      if (!hi_q) begin
        tck_d = 1'b1;
        hi_d  = 1'b1;
        div_d = '0;
        if (st_q == SHIFT) sh_d[per_q[IW-1:0]] = i_tdo;
      end else begin
        go = 1'b1;
        if (per_q == last) begin
          nper = 16'd0;
          unique case (st_q)
            INIT:    nst = IDLE;
            PRE:     nst = SHIFT;
            SHIFT:   nst = POST;
            default: nst = DONE;
          endcase
        end else begin
          nper = per_q + 16'd1;
        end
      end
    end else begin
      div_d = div_q + DW'(1);
    end
    if (go) begin
      st_d  = nst;
      per_d = nper;
      div_d = '0;
      hi_d  = 1'b0;
      tck_d = 1'b0;
      tdi_d = 1'b0;
      unique case (nst)
        INIT: begin
          tms_d = (nper != 16'(INIT_N - 1));
`ifdef JTAG_HOST_TRST_EN
          trst_d = (nper >= 16'd2);
`endif
        end
        PRE:   tms_d = ir_s ? (nper < 16'd2) : (nper == 16'd0);
        SHIFT: begin
          tms_d = (nper == 16'(REG_W - 1));
          tdi_d = dat_s[nper[IW-1:0]];
        end
        POST:    tms_d = (nper == 16'd0);
        default: tms_d = tms_q;
      endcase
      if (nst == DONE) rsp_d = sh_q;
    end
  end

  assign o_tck          = tck_q;
  assign o_tms          = tms_q;
  assign o_tdi          = tdi_q;
  assign cmd.o_ready    = (st_q == IDLE) || (st_q == DONE);
  assign cmd.o_rspValid = (st_q == DONE);
  assign cmd.o_rspData  = rsp_q;
`ifdef JTAG_HOST_TRST_EN
  assign o_trst_n       = trst_q;
`endif

endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host: directed scans against a small TAP target model,
// scoreboard queue checked by a monitor on o_rspValid.
module tb_jtag_host;
  localparam int W = 8, DIV = 4, HP = 2 * DIV;
  localparam int BSR = 8'h3C, IRCAP = 8'hC1;
`ifdef JTAG_HOST_TRST_EN
  localparam int INIT_N = 8;
`else
  localparam int INIT_N = 6;
`endif

  typedef struct {
    int d;
    int acc;
    int lat;
  } exp_t;

  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR
  } tap_e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tck, tms, tdi;
  logic tdo = 1'b0;
`ifdef JTAG_HOST_TRST_EN
  logic trst_n;
`else
  logic trst_n = 1'b1;
`endif

  jtag_host_if #(.REG_W(W)) bus ();

  jtag_host #(.REG_W(W), .CLK_DIV(DIV)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .cmd     (bus),
    .o_tck   (tck),
    .o_tms   (tms),
    .o_tdi   (tdi),
`ifdef JTAG_HOST_TRST_EN
    .o_trst_n(trst_n),
`endif
    .i_tdo   (tdo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TCK history: TMS/TDI seen by the target at each rising edge
  int   ntck = 0;
  logic tms_h [0:4095];
  logic tdi_h [0:4095];
  always @(posedge tck) begin
    tms_h[ntck[11:0]] <= tms;
    tdi_h[ntck[11:0]] <= tdi;
    ntck <= ntck + 1;
  end

  // Target TAP model
  tap_e       tap_st = TLR;
  logic [7:0] dsr = '0, isr = '0, user = '0, irr = '0;
  logic       park = 1'b0;
  always @(posedge tck or posedge park) begin
    if (park) tap_st <= PAUIR;
    else begin
      unique case (tap_st)
        TLR:   tap_st <= tms ? TLR   : RTI;
        RTI:   tap_st <= tms ? SELDR : RTI;
        SELDR: tap_st <= tms ? SELIR : CAPDR;
        CAPDR: tap_st <= tms ? EX1DR : SHDR;
        SHDR:  tap_st <= tms ? EX1DR : SHDR;
        EX1DR: tap_st <= tms ? UPDR  : PAUDR;
        PAUDR: tap_st <= tms ? EX2DR : PAUDR;
        EX2DR: tap_st <= tms ? UPDR  : SHDR;
        UPDR:  tap_st <= tms ? SELDR : RTI;
        SELIR: tap_st <= tms ? TLR   : CAPIR;
        CAPIR: tap_st <= tms ? EX1IR : SHIR;
        SHIR:  tap_st <= tms ? EX1IR : SHIR;
        EX1IR: tap_st <= tms ? UPIR  : PAUIR;
        PAUIR: tap_st <= tms ? EX2IR : PAUIR;
        EX2IR: tap_st <= tms ? UPIR  : SHIR;
        default: tap_st <= tms ? SELDR : RTI;
      endcase
      case (tap_st)
        CAPDR: dsr <= 8'(BSR);
        SHDR:  dsr <= {tdi, dsr[7:1]};
        UPDR:  user <= dsr;
        CAPIR: isr <= 8'(IRCAP);
        SHIR:  isr <= {tdi, isr[7:1]};
        UPIR:  irr <= isr;
        default: ;
      endcase
    end
  end
  always @(negedge tck) tdo <= (tap_st == SHIR) ? isr[0] : dsr[0];

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   start = 0;

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got=timeout want=event", nm);
  endtask

  task automatic mon();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_rspValid) begin
        if (exp_q.size() == 0) fail("spurious_rsp");
        else begin
          e = exp_q.pop_front();
          chk("rsp_data", int'(bus.o_rspData), e.d);
          chk("rsp_lat", cyc - e.acc, e.lat);
        end
      end
    end
  endtask

  // Expected TMS/TDI streams from the scan definition
  task automatic exp_scan(input logic ir, input logic [7:0] d,
                          output int t, output int di, output int n);
    n = 0; t = 0; di = 0;
    t[0] = 1'b1;
    t[1] = ir;
    n = ir ? 4 : 3;
    for (int k = 0; k < W; k++) begin
      t[n] = (k == W - 1);
      di[n] = d[k];
      n++;
    end
    t[n] = 1'b1;
    n += 2;
  endtask

  task automatic chk_stream(input string nm, input int t, input int di, input int n);
    int gt, gd;
    gt = 0; gd = 0;
    chk({nm, "_periods"}, ntck - start, n);
    for (int i = 0; i < n && i < 32; i++) begin
      gt[i] = tms_h[(start + i) % 4096];
      gd[i] = tdi_h[(start + i) % 4096];
    end
    chk({nm, "_tms"}, gt, t);
    chk({nm, "_tdi"}, gd, di);
  endtask

  task automatic send(input logic ir, input logic tr, input logic [7:0] d,
                      output int acc);
    exp_t e;
    bus.i_isIr = ir;
    bus.i_tapReset = tr;
    bus.i_data = d;
    bus.i_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 3000 && !bus.o_ready; i++) @(negedge clk);
    if (!bus.o_ready) fail("accept_wait");
    else begin
      acc = cyc;
      start = ntck;
      if (!tr) begin
        e.d = ir ? IRCAP : BSR;
        e.acc = cyc;
        e.lat = ((ir ? W + 6 : W + 5) * HP) + 1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_done(output int lo);
    lo = 0;
    @(negedge clk);
    bus.i_valid = 1'b0;
    if (!trst_n) lo++;
    for (int i = 0; i < 3000 && !bus.o_ready; i++) begin
      @(negedge clk);
      if (!trst_n) lo++;
    end
    if (!bus.o_ready) fail("done_wait");
  endtask

  task automatic release_init();
    int rel;
    @(negedge clk);
    rel = cyc;
    start = ntck;
    rst_n = 1'b1;
    for (int i = 0; i < 500 && !bus.o_ready; i++) @(negedge clk);
    chk("init_ready_cyc", cyc - rel, INIT_N * HP + 1);
    chk_stream("init", (1 << (INIT_N - 1)) - 1, 0, INIT_N);
    chk("init_tap_rti", int'(tap_st), int'(RTI));
  endtask

  initial begin
    int a0, a1, a2, lo, t, di, n;
    bus.i_valid = 1'b0;
    bus.i_isIr = 1'b0;
    bus.i_tapReset = 1'b0;
    bus.i_data = '0;
    fork
      mon();
    join_none
    #22;
    chk("rst_tck", int'(tck), 0);
    chk("rst_tms", int'(tms), 1);
    chk("rst_tdi", int'(tdi), 0);
    chk("rst_ready", int'(bus.o_ready), 0);
    chk("rst_rspv", int'(bus.o_rspValid), 0);
    chk("rst_rspd", int'(bus.o_rspData), 0);
    release_init();

    send(1'b0, 1'b0, 8'hA5, a0);
    wait_done(lo);
    exp_scan(1'b0, 8'hA5, t, di, n);
    chk_stream("dr_a5", t, di, n);
    chk("dr_a5_user", int'(user), 8'hA5);

    @(negedge clk);
    send(1'b1, 1'b0, 8'h01, a0);
    wait_done(lo);
    exp_scan(1'b1, 8'h01, t, di, n);
    chk_stream("ir_01", t, di, n);
    chk("ir_01_reg", int'(irr), 8'h01);

    @(negedge clk);
    send(1'b0, 1'b0, 8'h11, a0);
    @(negedge clk);
    send(1'b1, 1'b0, 8'h22, a1);
    @(negedge clk);
    send(1'b0, 1'b0, 8'h33, a2);
    wait_done(lo);
    chk("b2b_gap1", a1 - a0, (W + 5) * HP + 1);
    chk("b2b_gap2", a2 - a1, (W + 6) * HP + 1);
    chk("b2b_user", int'(user), 8'h33);
    chk("b2b_ir", int'(irr), 8'h22);

    @(negedge clk);
    send(1'b0, 1'b0, 8'h5A, a0);
    @(negedge clk);
    bus.i_valid = 1'b0;
    for (int i = 0; i < 500 && ntck < start + 7; i++) @(negedge clk);
    if (ntck < start + 7) fail("mid_scan_wait");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tck", int'(tck), 0);
    chk("arst_tms", int'(tms), 1);
    chk("arst_tdi", int'(tdi), 0);
    chk("arst_ready", int'(bus.o_ready), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    release_init();
    send(1'b0, 1'b0, 8'h96, a0);
    wait_done(lo);
    chk("arst_dr_user", int'(user), 8'h96);

    @(negedge clk);
    park = 1'b1;
    #1;
    park = 1'b0;
    send(1'b0, 1'b1, 8'hFF, a0);
    wait_done(lo);
    chk_stream("tapreset", (1 << (INIT_N - 1)) - 1, 0, INIT_N);
    chk("tapreset_rti", int'(tap_st), int'(RTI));
    chk("tapreset_rspd", int'(bus.o_rspData), BSR);
`ifdef JTAG_HOST_TRST_EN
    chk("tapreset_trst_lo", lo, 2 * HP);
`endif
    @(negedge clk);
    send(1'b0, 1'b0, 8'hC3, a0);
    wait_done(lo);
    chk("post_reset_user", int'(user), 8'hC3);

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtag_host.md
Name: jtag_host

Overview:
- Host-side JTAG driver that produces TCK/TMS/TDI and samples TDO to drive a `jtag` target (TAP, shift, instruction and data registers).
- Accepts one IR-scan or DR-scan command per valid/ready handshake.
- Walks the target TAP through the full state sequence, shifts REG_W bits LSB-first, and returns the captured TDO bits.
- Used by bring-up logic and testbenches as the initiator end of the JTAG link.

Parameters:
- REG_W, 8: scan length in bits; equals the target's shift-register width.
- CLK_DIV, 4: i_clk cycles per TCK half-period; must be ≥ 2.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  command request.
- o_ready  output  1  host idle; command accepted when i_valid && o_ready.
- i_isIr  input  1  1 = IR scan, 0 = DR scan; sampled at accept.
- i_tapReset  input  1  1 = run TMS reset sequence instead of a scan; sampled at accept; has priority over i_isIr.
- i_data  input  REG_W  TDI bits, LSB shifted first; sampled at accept.
- o_rspValid  output  1  one-cycle pulse when scan data is available.
- o_rspData  output  REG_W  TDO bits; bit i = i-th shifted-out bit; held until next o_rspValid.
- o_tck  output  1  JTAG clock, registered.
- o_tms  output  1  JTAG TMS, registered.
- o_tdi  output  1  JTAG TDI, registered.
- i_tdo  input  1  JTAG TDO from target.

Behaviour:
- Reset values: o_tck=0, o_tms=1, o_tdi=0, o_ready=0, o_rspValid=0, o_rspData=0.
- On reset release, runs INIT automatically; o_ready rises the cycle after INIT completes.
- TCK period = 2*CLK_DIV i_clk cycles: low half first, then high half. o_tck idles low.
- o_tms/o_tdi change only in the cycle o_tck goes low (start of a period).
- i_tdo is sampled in the i_clk cycle where o_tck goes 0→1 (the target's rising edge).
- States: INIT, IDLE, PRE, SHIFT, POST, DONE.
- One 16-bit-or-smaller TCK-period counter, plus a half-period divider counter.
- TMS sequences (one value per TCK period):
  - INIT / tapReset: 1,1,1,1,1,0 = 6 periods, ending in Run-Test/Idle.
  - DR scan: PRE 1,0,0; SHIFT REG_W periods with TMS=0, except the last period TMS=1; POST 1,0. Total REG_W+5 periods.
  - IR scan: PRE 1,1,0,0; SHIFT as DR; POST 1,0. Total REG_W+6 periods.
- SHIFT: o_tdi = i_data[k] in shift period k (k=0..REG_W-1). TDO sampled at the rising edge of period k goes to o_rspData[k] via an internal shift register.
- o_tdi = 0 outside SHIFT.
- DONE: exactly one cycle after the last period's high half ends.
  - o_rspValid=1 and o_rspData updated.
  - o_ready=1 in the same cycle.
  - A new command can be accepted in that cycle.
- tapReset commands never pulse o_rspValid; o_rspData is unchanged.
- i_valid while o_ready=0 is ignored; no queuing.
- Command fields are latched at accept; later input changes have no effect.
- Reset mid-scan: all outputs go to reset values immediately (async); INIT reruns after release; the partial scan is discarded with no o_rspValid.
- REG_W=1: SHIFT is one period with TMS=1.
- Latency from accept to o_rspValid (accept cycle excluded): (periods × 2*CLK_DIV) + 1 cycles. DR with REG_W=8, CLK_DIV=4: 13×8+1 = 105.

Optional Feature:
- Macro: JTAG_HOST_TRST_EN.
- Defined:
  - Adds port o_trst_n (output, 1).
  - Reset value 0; held 0 for the first 2 TCK periods of every INIT or tapReset sequence (TMS=1, o_tck toggling), then 1.
  - The 6-period TMS sequence follows, so sequences grow to 8 periods.
- Not defined: no port; TMS-only reset as above.

Test Plan:
- Reset release, CLK_DIV=4 → o_tck toggles 6 times with TMS 1,1,1,1,1,0; o_ready=1 at cycle 49 after release; o_tdi stays 0.
- DR scan, i_data=8'hA5, target BSR=8'h3C → TDI bits 1,0,1,0,0,1,0,1 in shift periods; o_rspData=8'h3C; target o_userData=8'hA5; o_rspValid 105 cycles after accept.
- IR scan, i_data=8'h01 → TMS stream 1,1,0,0, then 0×7, 1, then 1,0; o_rspData equals the target's IR capture value; 14 TCK periods.
- i_valid held high with alternating i_isIr across 3 commands → back-to-back accepts at each DONE cycle; 3 o_rspValid pulses; no dropped or duplicated scan.
- Async reset asserted at shift period 3 of a DR scan → o_tck=0 and o_tms=1 immediately; no o_rspValid; INIT reruns; next DR scan returns correct data.
- tapReset command while target sits in a non-idle IR state → 6 TMS=1,…,0 periods; no o_rspValid; a following DR scan succeeds. With JTAG_HOST_TRST_EN, o_trst_n is low for 16 cycles.
